// File: rtl/lcms2012_pkg.sv
// LCMS2012 measurement controller: shared types, mode codes and timing defaults.
package lcms2012_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        READ,
        DONE
    } adc_state_e;

    localparam logic [1:0] MODE_HW_CDS = 2'b01;
    localparam logic [1:0] MODE_SW_CDS = 2'b10;

    localparam int DEF_MEM_ADDR_WIDTH = 10;
    localparam int DEF_CLK_PER_US     = 100;
    localparam int DEF_CNV_CYCLES     = 70;
    localparam int DEF_SCK_HALF       = 5;

    // Half-open window [lo, lo+w) with a 17-bit upper bound so it never wraps.
    function automatic logic in_window(
        input logic [15:0] t,
        input logic [15:0] lo,
        input logic [15:0] w
    );
        logic [16:0] hi;
        hi = {1'b0, lo} + {1'b0, w};
        return (t >= lo) && ({1'b0, t} < hi);
    endfunction

endpackage

// File: rtl/lcms2012_project_adc_spi.sv
// Serial 16-bit ADC sequencer: CNV pulse, SCK divider, MSB-first shift-in.
module lcms2012_project_adc_spi
    import lcms2012_pkg::*;
#(
    parameter int CNV_CYCLES = DEF_CNV_CYCLES,
    parameter int SCK_HALF   = DEF_SCK_HALF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        sdo_i,
    output logic        cnv_o,
    output logic        sck_o,
    output logic        done_o,
    output logic [15:0] data_o
);

    localparam logic [15:0] CNV_LAST = 16'(CNV_CYCLES - 1);
    localparam logic [15:0] HALF_LAST = 16'(SCK_HALF - 1);

    adc_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        sck_q, sck_d;
    logic [15:0] sh_q, sh_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                if (cnt_q == CNV_LAST) begin
                    state_d = READ;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            READ: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    sck_d = !sck_q;
                    // Sample on the rising SCK edge, count bits on the falling one.
                    if (!sck_q) begin
                        sh_d = {sh_q[14:0], sdo_i};
                    end else if (bit_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cnv_o  = (state_q == CONV);
    assign done_o = (state_q == DONE);
    assign sck_o  = sck_q;
    assign data_o = sh_q;

endmodule

// File: rtl/lcms2012_project.sv
// LCMS2012 controller top: reset/CDS timing, ADC sampler, result FIFO.
// Optional LCMS_DIGITAL_CDS_EN: baseline-subtracted results in SW CDS mode.
module lcms2012_project
    import lcms2012_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int CLK_PER_US     = DEF_CLK_PER_US,
    parameter int CNV_CYCLES     = DEF_CNV_CYCLES,
    parameter int SCK_HALF       = DEF_SCK_HALF
) (
    input  logic        s_clk,
    input  logic        reset,
    input  logic        start_meas,
    input  logic [15:0] reset_period_i,
    input  logic [15:0] int_reset_duration_i,
    input  logic [15:0] post_reset_duration_i,
    input  logic [15:0] v_sampling_period_i,
    input  logic [15:0] cds_time1_delay_i,
    input  logic [15:0] cds_time2_delay_i,
    input  logic [15:0] cds_width_i,
    input  logic        mode_i,
    input  logic        mode2_i,
    input  logic        infilter_seln_i,
    input  logic        addr0_i,
    input  logic        addr1_i,
    input  logic        addr2_i,
    input  logic        addr3_i,
    input  logic        int_capselect1_i,
    input  logic        int_capselect2_i,
    input  logic        res_select_i,
    input  logic        post_capselect_i,
    input  logic        post_bypass_i,
    input  logic        lpf_bypass_i,
    input  logic        cds_bypass_i,
    output logic        INFILTER_SELN,
    output logic        ADDR0,
    output logic        ADDR1,
    output logic        ADDR2,
    output logic        ADDR3,
    output logic        INT_CAPSELECT1,
    output logic        INT_CAPSELECT2,
    output logic        RES_SELECT,
    output logic        POST_CAPSELECT,
    output logic        POST_BYPASS,
    output logic        LPF_BYPASS,
    output logic        CDS_BYPASS,
    output logic        INT_RESET,
    output logic        POST_RESET,
    output logic        CDS_CLK1,
    output logic        CDS_CLK2,
    output logic        ADC_CNV,
    output logic        ADC_SCK,
    output logic        ADC_SDI,
    input  logic        ADC_SDO,
    output logic [15:0] adc_result,
    output logic        adc_cnv_start,
    output logic        adc_fs_pulse,
    input  logic        ti_out_data_en,
    output logic [15:0] ti_out_data,
    output logic [15:0] ti_out_available,
    output logic [7:0]  a_led
);

    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam logic [15:0] PRE_LAST = 16'(CLK_PER_US - 1);
    localparam logic [MEM_ADDR_WIDTH:0] FULL_CNT = (MEM_ADDR_WIDTH + 1)'(DEPTH);

    logic [15:0] pcnt_q, rcnt_q, scnt_q;
    logic        tick, trig, hw_cds;
    logic        int_reset_q, post_reset_q, cds1_q, cds2_q;
    logic        cnv_start_q, fs_q, ovf_q;
    logic [15:0] result_q, dout_q;
    logic [11:0] cfg_q;
    logic [7:0]  led_q;

    logic        done, full, do_push, do_pop, push_req;
    logic [15:0] adc_data, push_word;
    logic [15:0] mem_q [DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [MEM_ADDR_WIDTH:0]   cnt_q;

    assign tick   = (pcnt_q == PRE_LAST);
    assign trig   = start_meas && tick && (scnt_q == '0);
    assign hw_cds = start_meas && ({mode_i, mode2_i} == MODE_HW_CDS);

    always_ff @(posedge s_clk) begin
        if (!reset) begin
            pcnt_q       <= '0;
            rcnt_q       <= '0;
            scnt_q       <= '0;
            int_reset_q  <= 1'b1;
            post_reset_q <= 1'b1;
            cds1_q       <= 1'b0;
            cds2_q       <= 1'b0;
            cnv_start_q  <= 1'b0;
            cfg_q        <= '0;
        end else begin
            pcnt_q <= tick ? '0 : pcnt_q + 16'd1;
            if (!start_meas) begin
                rcnt_q <= '0;
                scnt_q <= '0;
            end else if (tick) begin
                // ">=" keeps the counters sane if a period is shortened mid-run.
                rcnt_q <= (reset_period_i <= 16'd1 ||
                           rcnt_q >= reset_period_i - 16'd1) ? '0 : rcnt_q + 16'd1;
                scnt_q <= (v_sampling_period_i <= 16'd1 ||
                           scnt_q >= v_sampling_period_i - 16'd1) ? '0 : scnt_q + 16'd1;
            end
            int_reset_q  <= !start_meas || (rcnt_q < int_reset_duration_i);
            post_reset_q <= !start_meas || (rcnt_q < post_reset_duration_i);
            cds1_q <= hw_cds && in_window(rcnt_q, cds_time1_delay_i, cds_width_i);
            cds2_q <= hw_cds && in_window(rcnt_q, cds_time2_delay_i, cds_width_i);
            cnv_start_q <= trig;
            cfg_q <= {infilter_seln_i, addr0_i, addr1_i, addr2_i, addr3_i,
                      int_capselect1_i, int_capselect2_i, res_select_i,
                      post_capselect_i, post_bypass_i, lpf_bypass_i, cds_bypass_i};
        end
    end

    lcms2012_project_adc_spi #(
        .CNV_CYCLES(CNV_CYCLES),
        .SCK_HALF  (SCK_HALF)
    ) u_adc (
        .clk_i  (s_clk),
        .rst_ni (reset),
        .start_i(trig),
        .sdo_i  (ADC_SDO),
        .cnv_o  (ADC_CNV),
        .sck_o  (ADC_SCK),
        .done_o (done),
        .data_o (adc_data)
    );

`ifdef LCMS_DIGITAL_CDS_EN
    logic        sw_cds, int_prev_q, base_pend_q;
    logic [15:0] base_q;

    assign sw_cds = ({mode_i, mode2_i} == MODE_SW_CDS);

    always_comb begin
        push_req  = done;
        push_word = adc_data;
        if (sw_cds) begin
            push_req  = done && !base_pend_q;
            push_word = adc_data - base_q;
        end
    end

    always_ff @(posedge s_clk) begin
        if (!reset) begin
            int_prev_q  <= 1'b1;
            base_pend_q <= 1'b0;
            base_q      <= '0;
        end else begin
            int_prev_q <= int_reset_q;
            if (done && sw_cds && base_pend_q) begin
                base_q      <= adc_data;
                base_pend_q <= 1'b0;
            end
            if (int_prev_q && !int_reset_q) begin
                base_pend_q <= 1'b1;
            end
        end
    end
`else
    assign push_req  = done;
    assign push_word = adc_data;
`endif

    assign full    = (cnt_q == FULL_CNT);
    assign do_push = push_req && !full;
    assign do_pop  = ti_out_data_en && (cnt_q != '0);

    always_ff @(posedge s_clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_word;
        end
    end

    always_ff @(posedge s_clk) begin
        if (!reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            dout_q   <= '0;
            result_q <= '0;
            fs_q     <= 1'b0;
            led_q    <= 8'h08;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
                dout_q <= mem_q[rptr_q];
            end
            if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
            if (push_req && full) ovf_q <= 1'b1;
            if (done) result_q <= adc_data;
            fs_q  <= done;
            led_q <= {4'b0, cnt_q == '0, int_reset_q, ovf_q, start_meas};
        end
    end

    assign {INFILTER_SELN, ADDR0, ADDR1, ADDR2, ADDR3,
            INT_CAPSELECT1, INT_CAPSELECT2, RES_SELECT,
            POST_CAPSELECT, POST_BYPASS, LPF_BYPASS, CDS_BYPASS} = cfg_q;

    assign INT_RESET        = int_reset_q;
    assign POST_RESET       = post_reset_q;
    assign CDS_CLK1         = cds1_q;
    assign CDS_CLK2         = cds2_q;
    assign ADC_SDI          = 1'b0;
    assign adc_result       = result_q;
    assign adc_cnv_start    = cnv_start_q;
    assign adc_fs_pulse     = fs_q;
    assign ti_out_data      = dout_q;
    assign ti_out_available = 16'(cnt_q);
    assign a_led            = led_q;

endmodule

// File: tb/tb_lcms2012_project.sv
// Scoreboard bench for lcms2012_project: timing, HW CDS, ADC, FIFO drain, overflow.
module tb_lcms2012_project;

    localparam int DEPTH = 16;

    logic        s_clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_meas = 1'b0;
    logic [15:0] reset_period_i = '0, int_reset_duration_i = '0;
    logic [15:0] post_reset_duration_i = '0, v_sampling_period_i = '0;
    logic [15:0] cds_time1_delay_i = '0, cds_time2_delay_i = '0, cds_width_i = '0;
    logic        mode_i = 1'b0, mode2_i = 1'b0;
    logic [11:0] cfg = '0;
    logic        INFILTER_SELN, ADDR0, ADDR1, ADDR2, ADDR3;
    logic        INT_CAPSELECT1, INT_CAPSELECT2, RES_SELECT;
    logic        POST_CAPSELECT, POST_BYPASS, LPF_BYPASS, CDS_BYPASS;
    logic        INT_RESET, POST_RESET, CDS_CLK1, CDS_CLK2;
    logic        ADC_CNV, ADC_SCK, ADC_SDI;
    logic        ADC_SDO = 1'b0;
    logic [15:0] adc_result;
    logic        adc_cnv_start, adc_fs_pulse;
    logic        ti_out_data_en = 1'b0;
    logic [15:0] ti_out_data, ti_out_available;
    logic [7:0]  a_led;

    always #5 s_clk = ~s_clk;

    lcms2012_project #(
        .MEM_ADDR_WIDTH(4),
        .CLK_PER_US    (4),
        .CNV_CYCLES    (6),
        .SCK_HALF      (1)
    ) dut (
        .s_clk(s_clk), .reset(reset), .start_meas(start_meas),
        .reset_period_i(reset_period_i),
        .int_reset_duration_i(int_reset_duration_i),
        .post_reset_duration_i(post_reset_duration_i),
        .v_sampling_period_i(v_sampling_period_i),
        .cds_time1_delay_i(cds_time1_delay_i),
        .cds_time2_delay_i(cds_time2_delay_i),
        .cds_width_i(cds_width_i),
        .mode_i(mode_i), .mode2_i(mode2_i),
        .infilter_seln_i(cfg[11]), .addr0_i(cfg[10]), .addr1_i(cfg[9]),
        .addr2_i(cfg[8]), .addr3_i(cfg[7]),
        .int_capselect1_i(cfg[6]), .int_capselect2_i(cfg[5]),
        .res_select_i(cfg[4]), .post_capselect_i(cfg[3]),
        .post_bypass_i(cfg[2]), .lpf_bypass_i(cfg[1]), .cds_bypass_i(cfg[0]),
        .INFILTER_SELN(INFILTER_SELN), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .ADDR2(ADDR2), .ADDR3(ADDR3),
        .INT_CAPSELECT1(INT_CAPSELECT1), .INT_CAPSELECT2(INT_CAPSELECT2),
        .RES_SELECT(RES_SELECT), .POST_CAPSELECT(POST_CAPSELECT),
        .POST_BYPASS(POST_BYPASS), .LPF_BYPASS(LPF_BYPASS),
        .CDS_BYPASS(CDS_BYPASS),
        .INT_RESET(INT_RESET), .POST_RESET(POST_RESET),
        .CDS_CLK1(CDS_CLK1), .CDS_CLK2(CDS_CLK2),
        .ADC_CNV(ADC_CNV), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI),
        .ADC_SDO(ADC_SDO),
        .adc_result(adc_result), .adc_cnv_start(adc_cnv_start),
        .adc_fs_pulse(adc_fs_pulse),
        .ti_out_data_en(ti_out_data_en), .ti_out_data(ti_out_data),
        .ti_out_available(ti_out_available), .a_led(a_led)
    );

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ADC word table (first entry is the reference conversion word).
    logic [15:0] tab [8] = '{16'h87C4, 16'h1234, 16'hFFFF, 16'h0001,
                             16'hA5A5, 16'h5A5A, 16'h8000, 16'h7FFE};
    logic [15:0] cur = '0;
    int          bi = 0;
    int          kconv = 0;
    logic [15:0] res_q[$];
    logic [15:0] mfifo[$];
    logic [15:0] exp_pop[$];
    logic [15:0] last_pop = '0;

    // ADC model: word issued at CNV rise, bits shifted out on SCK falls.
    always @(posedge ADC_CNV) begin
        cur = tab[kconv % 8];
        bi = 15;
        ADC_SDO = cur[15];
        res_q.push_back(cur);
        if (mfifo.size() < DEPTH) mfifo.push_back(cur);
        kconv++;
    end

    always @(negedge ADC_SCK) begin
        if (bi > 0) bi--;
        ADC_SDO = cur[bi];
    end

    int  cyc = 0;
    always @(posedge s_clk) cyc++;

    logic pchk = 1'b0;
    always @(posedge s_clk) begin
        if (ti_out_data_en === 1'b1 && mfifo.size() > 0) begin
            exp_pop.push_back(mfifo.pop_front());
            pchk <= 1'b1;
        end else begin
            pchk <= 1'b0;
        end
    end

    int fs_cnt = 0;
    int last_fs = -1;
    bit chk_ivl = 0;

    always @(negedge s_clk) begin
        if (adc_fs_pulse === 1'b1) begin
            fs_cnt++;
            if (res_q.size() == 0) chk("fs_unexpected", 32'(adc_result), 32'hFFFF_FFFF);
            else chk("adc_result", 32'(adc_result), 32'(res_q.pop_front()));
            chk("avail_on_fs", 32'(ti_out_available), 32'(mfifo.size()));
            if (chk_ivl && last_fs >= 0) chk("fs_interval", 32'(cyc - last_fs), 32'd80);
            last_fs = cyc;
        end
        if (pchk) begin
            if (exp_pop.size() == 0) chk("pop_unexpected", 32'(ti_out_data), 32'hFFFF_FFFF);
            else begin
                last_pop = exp_pop.pop_front();
                chk("pop_data", 32'(ti_out_data), 32'(last_pop));
            end
        end
    end

    task automatic wait_fs(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge s_clk);
            if (fs_cnt >= n) break;
        end
        if (i == budget) chk("fs_timeout", 32'(fs_cnt), 32'(n));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge s_clk);
            #1 ti_out_data_en = 1'b1;
        end
        @(posedge s_clk);
        #1 ti_out_data_en = 1'b0;
        repeat (4) @(negedge s_clk);
    endtask

    initial begin
        int n_int, n_post, n_c1, n_c2, n_both, t_int, d1, d2;
        logic p_int, p_c1, p_c2;

        // Reset
        cfg = 12'hA5C;
        repeat (5) @(posedge s_clk);
        @(negedge s_clk);
        chk("rst_int_reset", 32'(INT_RESET), 32'd1);
        chk("rst_post_reset", 32'(POST_RESET), 32'd1);
        chk("rst_adc_cnv", 32'(ADC_CNV), 32'd0);
        chk("rst_avail", 32'(ti_out_available), 32'd0);
        chk("rst_led", 32'(a_led), 32'h08);
        chk("rst_cds", 32'({CDS_CLK1, CDS_CLK2}), 32'd0);
        chk("rst_cfg", 32'({INFILTER_SELN, ADDR0, ADDR1, ADDR2, ADDR3}), 32'd0);

        reset = 1'b1;
        reset_period_i = 16'd100;
        int_reset_duration_i = 16'd10;
        post_reset_duration_i = 16'd10;
        cds_time1_delay_i = 16'd2;
        cds_time2_delay_i = 16'd90;
        cds_width_i = 16'd2;
        v_sampling_period_i = 16'd60000;
        repeat (20) @(negedge s_clk);
        chk("cfg_pass", 32'({INFILTER_SELN, ADDR0, ADDR1, ADDR2, ADDR3,
            INT_CAPSELECT1, INT_CAPSELECT2, RES_SELECT, POST_CAPSELECT,
            POST_BYPASS, LPF_BYPASS, CDS_BYPASS}), 32'hA5C);
        chk("hold_int_reset", 32'(INT_RESET), 32'd1);
        chk("hold_cds", 32'({CDS_CLK1, CDS_CLK2}), 32'd0);
        chk("sdi_tied", 32'(ADC_SDI), 32'd0);

        // HW CDS timing over two full reset periods (400 cycles each)
        mode_i = 1'b0; mode2_i = 1'b1;
        start_meas = 1'b1;
        repeat (1200) @(negedge s_clk);
        chk("led_start", 32'(a_led[0]), 32'd1);
        n_int = 0; n_post = 0; n_c1 = 0; n_c2 = 0; n_both = 0;
        t_int = -1; d1 = -1; d2 = -1;
        p_int = INT_RESET; p_c1 = CDS_CLK1; p_c2 = CDS_CLK2;
        for (int i = 0; i < 800; i++) begin
            @(negedge s_clk);
            n_int += int'(INT_RESET);
            n_post += int'(POST_RESET);
            n_c1 += int'(CDS_CLK1);
            n_c2 += int'(CDS_CLK2);
            n_both += int'(CDS_CLK1 & CDS_CLK2);
            if (INT_RESET && !p_int) t_int = i;
            if (CDS_CLK1 && !p_c1 && t_int >= 0) d1 = i - t_int;
            if (CDS_CLK2 && !p_c2 && t_int >= 0) d2 = i - t_int;
            p_int = INT_RESET; p_c1 = CDS_CLK1; p_c2 = CDS_CLK2;
        end
        chk("int_reset_high", 32'(n_int), 32'd80);
        chk("post_reset_high", 32'(n_post), 32'd80);
        chk("cds1_high", 32'(n_c1), 32'd16);
        chk("cds2_high", 32'(n_c2), 32'd16);
        chk("cds_overlap", 32'(n_both), 32'd0);
        chk("cds1_offset", 32'(d1), 32'd8);
        chk("cds2_offset", 32'(d2), 32'd360);

        // SW CDS code: no CDS clocks
        mode_i = 1'b1; mode2_i = 1'b0;
        n_c1 = 0; n_c2 = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge s_clk);
            n_c1 += int'(CDS_CLK1);
            n_c2 += int'(CDS_CLK2);
        end
        chk("sw_cds1_off", 32'(n_c1), 32'd0);
        chk("sw_cds2_off", 32'(n_c2), 32'd0);

        // ADC: 10 results in total, one every 80 cycles
        start_meas = 1'b0;
        mode_i = 1'b0; mode2_i = 1'b0;
        v_sampling_period_i = 16'd20;
        repeat (10) @(posedge s_clk);
        last_fs = -1;
        chk_ivl = 1;
        #1 start_meas = 1'b1;
        wait_fs(10, 2000);
        #1 start_meas = 1'b0;
        chk_ivl = 0;
        repeat (100) @(negedge s_clk);
        chk("avail_10", 32'(ti_out_available), 32'd10);
        chk("led_not_empty", 32'(a_led[3]), 32'd0);

        // Drain 10 words with 16 pop cycles
        drain(16);
        chk("drain_avail", 32'(ti_out_available), 32'd0);
        chk("drain_hold", 32'(ti_out_data), 32'(tab[1]));
        chk("led_empty", 32'(a_led[3]), 32'd1);
        chk("led_no_ovf", 32'(a_led[1]), 32'd0);

        // Overflow: 17 conversions into a 16-deep FIFO
        @(posedge s_clk);
        #1 start_meas = 1'b1;
        wait_fs(27, 3000);
        #1 start_meas = 1'b0;
        repeat (100) @(negedge s_clk);
        chk("ovf_avail", 32'(ti_out_available), 32'd16);
        chk("ovf_led", 32'(a_led[1]), 32'd1);
        drain(20);
        chk("ovf_last_kept", 32'(ti_out_data), 32'(tab[1]));
        chk("ovf_drained", 32'(ti_out_available), 32'd0);
        chk("ovf_sticky", 32'(a_led[1]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
